cond_exec_stage: RTL and testbench

- Decode-to-execute boundary of the pipelined ARM core, directly downstream of the decoder's control unit.
- Registers the decoder's D-stage control bundle into the E stage, with stall and flush.
- Holds the architectural NZCV flags register and evaluates the 4-bit condition field against it.
- Outputs E-stage control signals, with side-effecting controls gated by the condition result, to the ALU, the memory stage and PC select.

---
 rtl/cond_exec_stage_pkg.sv | 50 +++++
 rtl/cond_check.sv | 45 ++++
 rtl/cond_exec_stage.sv | 85 ++++++++
 tb/tb_cond_exec_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_exec_stage_pkg.sv
// Shared definitions for the decode-to-execute boundary: condition codes,
// NZCV bit positions and the E-stage control bundle with its bubble value.
package cond_exec_stage_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic       pcsrc;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [2:0] alu_control;
    logic [1:0] flag_write;
    logic [3:0] cond;
  } ctrl_t;

  // A bubble carries no side effects and an always-true condition.
  localparam ctrl_t CTRL_BUBBLE = '{
    pcsrc:       1'b0,
    reg_write:   1'b0,
    mem_write:   1'b0,
    mem_to_reg:  1'b0,
    alu_src:     1'b0,
    alu_control: 3'b000,
    flag_write:  2'b00,
    cond:        COND_AL
  };

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluator against NZCV.
// Define COND_NV_ALWAYS_EN to make condition 1111 behave like AL.
module cond_check
  import cond_exec_stage_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = !z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = !c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = !n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = !v;
      COND_HI: cond_ex_o = c && !z;
      COND_LS: cond_ex_o = !c || z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = !z && (n == v);
      COND_LE: cond_ex_o = z || (n != v);
      COND_AL: cond_ex_o = 1'b1;
`ifdef COND_NV_ALWAYS_EN
      COND_NV: cond_ex_o = 1'b1;
`else
      COND_NV: cond_ex_o = 1'b0;
`endif
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// D-to-E pipeline register with stall/flush, NZCV flags register and
// condition-gated E-stage controls. Honours COND_NV_ALWAYS_EN via cond_check.
module cond_exec_stage
  import cond_exec_stage_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic       PCSrcD,
  input  logic       RegWriteD,
  input  logic       MemWriteD,
  input  logic       MemtoRegD,
  input  logic       ALUSrcD,
  input  logic [2:0] ALUControlD,
  input  logic [1:0] FlagWriteD,
  input  logic [3:0] CondD,
  input  logic [3:0] ALUFlagsE,
  output logic       ALUSrcE,
  output logic       MemtoRegE,
  output logic [2:0] ALUControlE,
  output logic       PCSrcE,
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       CondExE,
  output logic [3:0] FlagsE
);

  ctrl_t      ctrl_d, ctrl_q;
  logic [3:0] flags_d, flags_q;
  logic       cond_ex;

  cond_check u_cond_check (
    .cond_i    (ctrl_q.cond),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  always_comb begin
    ctrl_d = ctrl_q;
    if (FlushE) begin
      ctrl_d = CTRL_BUBBLE;
    end else if (!StallE) begin
      ctrl_d.pcsrc       = PCSrcD;
      ctrl_d.reg_write   = RegWriteD;
      ctrl_d.mem_write   = MemWriteD;
      ctrl_d.mem_to_reg  = MemtoRegD;
      ctrl_d.alu_src     = ALUSrcD;
      ctrl_d.alu_control = ALUControlD;
      ctrl_d.flag_write  = FlagWriteD;
      ctrl_d.cond        = CondD;
    end
  end

  // The outgoing instruction retires its flags even when the incoming one is flushed.
  always_comb begin
    flags_d = flags_q;
    if (cond_ex && !StallE) begin
      if (ctrl_q.flag_write[1]) flags_d[FLAG_N:FLAG_Z] = ALUFlagsE[FLAG_N:FLAG_Z];
      if (ctrl_q.flag_write[0]) flags_d[FLAG_C:FLAG_V] = ALUFlagsE[FLAG_C:FLAG_V];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= CTRL_BUBBLE;
      flags_q <= FLAGS_RST;
    end else begin
      ctrl_q  <= ctrl_d;
      flags_q <= flags_d;
    end
  end

  assign ALUSrcE     = ctrl_q.alu_src;
  assign MemtoRegE   = ctrl_q.mem_to_reg;
  assign ALUControlE = ctrl_q.alu_control;
  assign PCSrcE      = ctrl_q.pcsrc     & cond_ex;
  assign RegWriteE   = ctrl_q.reg_write & cond_ex;
  assign MemWriteE   = ctrl_q.mem_write & cond_ex;
  assign CondExE     = cond_ex;
  assign FlagsE      = flags_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed bench for cond_exec_stage: stimulus pushes expected E-stage
// output words into a queue, a monitor pops and compares them each cycle.
module tb_cond_exec_stage;

  localparam int         W      = 13;
  localparam logic [3:0] F_RST  = 4'b0000;
  localparam logic [3:0] AL     = 4'b1110;
  localparam logic [3:0] EQ     = 4'b0000;
  localparam logic [3:0] NE     = 4'b0001;

  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] fw;
    logic       rw;
    logic       mw;
    logic       pc;
    logic       alusrc;
    logic       mtr;
    logic [2:0] aluc;
  } d_t;

  logic       clk, reset, StallE, FlushE;
  logic       PCSrcD, RegWriteD, MemWriteD, MemtoRegD, ALUSrcD;
  logic [2:0] ALUControlD;
  logic [1:0] FlagWriteD;
  logic [3:0] CondD, ALUFlagsE;
  logic       ALUSrcE, MemtoRegE, PCSrcE, RegWriteE, MemWriteE, CondExE;
  logic [2:0] ALUControlE;
  logic [3:0] FlagsE;
  logic [W-1:0] dut_vec;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  string        exp_nm_q[$];

  int   total = 0;
  int   bad = 0;
  int   cycle_cnt = 0;
  logic mon_kick = 1'b0;

  d_t         m;
  logic [3:0] m_flags;

  cond_exec_stage #(.FLAGS_RST(F_RST)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .MemtoRegD(MemtoRegD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
    .FlagWriteD(FlagWriteD), .CondD(CondD), .ALUFlagsE(ALUFlagsE),
    .ALUSrcE(ALUSrcE), .MemtoRegE(MemtoRegE), .ALUControlE(ALUControlE),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .CondExE(CondExE), .FlagsE(FlagsE)
  );

  assign dut_vec = {ALUSrcE, MemtoRegE, ALUControlE, PCSrcE, RegWriteE,
                    MemWriteE, CondExE, FlagsE};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // ---------------- reference helpers ----------------
  function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (cond == 4'b1111) begin
`ifdef COND_NV_ALWAYS_EN
      return 1'b1;
`else
      return 1'b0;
`endif
    end
    if (cond == 4'b1110) return 1'b1;
    return base ^ cond[0];
  endfunction

  function automatic logic [W-1:0] pk(input logic alusrc, input logic mtr,
      input logic [2:0] aluc, input logic pc, input logic rw, input logic mw,
      input logic cex, input logic [3:0] fl);
    return {alusrc, mtr, aluc, pc, rw, mw, cex, fl};
  endfunction

  function automatic d_t ins(input logic [3:0] cond, input logic [1:0] fw,
      input logic rw, input logic mw, input logic pc, input logic alusrc,
      input logic mtr, input logic [2:0] aluc);
    d_t r;
    r.cond = cond; r.fw = fw; r.rw = rw; r.mw = mw; r.pc = pc;
    r.alusrc = alusrc; r.mtr = mtr; r.aluc = aluc;
    return r;
  endfunction

  function automatic d_t bubble();
    return ins(AL, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push(input string nm, input logic [W-1:0] e, input int cyc);
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc);
    exp_nm_q.push_back(nm);
  endtask

  task automatic hand(input string nm, input logic [W-1:0] e);
    push(nm, e, cycle_cnt);
  endtask

  // Called at posedge+2; drives one D vector plus ALUFlagsE for the
  // instruction currently in E, models the next edge, returns at posedge+2.
  task automatic step(input string nm, input d_t d, input logic [3:0] af,
                      input logic stall, input logic flush);
    logic cex;
    PCSrcD = d.pc; RegWriteD = d.rw; MemWriteD = d.mw; MemtoRegD = d.mtr;
    ALUSrcD = d.alusrc; ALUControlD = d.aluc; FlagWriteD = d.fw; CondD = d.cond;
    ALUFlagsE = af; StallE = stall; FlushE = flush;
    cex = ref_cond(m.cond, m_flags);
    if (m.fw[1] && cex && !stall) m_flags[3:2] = af[3:2];
    if (m.fw[0] && cex && !stall) m_flags[1:0] = af[1:0];
    if (flush) m = bubble();
    else if (!stall) m = d;
    cex = ref_cond(m.cond, m_flags);
    push(nm, pk(m.alusrc, m.mtr, m.aluc, m.pc & cex, m.rw & cex, m.mw & cex,
                cex, m_flags), cycle_cnt + 1);
    @(posedge clk);
    #2;
  endtask

  task automatic async_reset(input string nm);
    @(negedge clk);
    #1;
    reset = 1'b1;
    m = bubble();
    m_flags = F_RST;
    hand(nm, pk(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, F_RST));
    #1 mon_kick = 1'b1;
    #1 mon_kick = 1'b0;
    @(posedge clk);
    #2;
    hand({nm, "_held"}, pk(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, F_RST));
    reset = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk or posedge mon_kick) begin
    while (exp_q.size() > 0 && exp_cyc_q[0] <= cycle_cnt) begin
      logic [W-1:0] e;
      int           c;
      string        nm;
      e  = exp_q.pop_front();
      c  = exp_cyc_q.pop_front();
      nm = exp_nm_q.pop_front();
      total++;
      if (c != cycle_cnt || dut_vec !== e) begin
        bad++;
        $display("FAIL %s: cycle %0d got %b want %b (due cycle %0d)",
                 nm, cycle_cnt, dut_vec, e, c);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    d_t idle;
    idle = bubble();
    reset = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    PCSrcD = 1'b0; RegWriteD = 1'b0; MemWriteD = 1'b0; MemtoRegD = 1'b0;
    ALUSrcD = 1'b0; ALUControlD = 3'b000; FlagWriteD = 2'b00; CondD = AL;
    ALUFlagsE = 4'b0000;
    m = bubble();
    m_flags = F_RST;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    hand("rst_idle", pk(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000));
    reset = 1'b0;

    // CMP then EQ / NE consumers
    step("cmp_load", ins(AL, 2'b11, 0, 0, 0, 0, 0, 3'b000), 4'b0000, 0, 0);
    step("eq_after_cmp", ins(EQ, 2'b00, 1, 0, 0, 0, 0, 3'b000), 4'b0100, 0, 0);
    hand("eq_regwrite", pk(0, 0, 3'b000, 0, 1, 0, 1, 4'b0100));
    step("ne_after_cmp", ins(NE, 2'b00, 1, 0, 0, 0, 0, 3'b000), 4'b0000, 0, 0);
    hand("ne_regwrite", pk(0, 0, 3'b000, 0, 0, 0, 0, 4'b0100));

    // Partial flag write keeps C,V
    step("pw_set", ins(AL, 2'b11, 0, 0, 0, 0, 0, 3'b000), 4'b0000, 0, 0);
    step("pw_partial", ins(AL, 2'b10, 0, 0, 0, 0, 0, 3'b000), 4'b1010, 0, 0);
    step("pw_result", idle, 4'b0101, 0, 0);
    hand("pw_flags", pk(0, 0, 3'b000, 0, 0, 0, 1, 4'b0110));

    // Failed-condition store + branch + flag write
    step("fc_clear", ins(AL, 2'b11, 0, 0, 0, 0, 0, 3'b000), 4'b0000, 0, 0);
    step("fc_store", ins(EQ, 2'b11, 0, 1, 1, 0, 0, 3'b000), 4'b0000, 0, 0);
    hand("fc_gated", pk(0, 0, 3'b000, 0, 0, 0, 0, 4'b0000));
    step("fc_noflag", idle, 4'b1111, 0, 0);
    hand("fc_flags_kept", pk(0, 0, 3'b000, 0, 0, 0, 1, 4'b0000));

    // Flush beats stall
    step("sf_load", ins(AL, 2'b00, 1, 1, 1, 1, 0, 3'b101), 4'b0000, 0, 0);
    hand("sf_loaded", pk(1, 0, 3'b101, 1, 1, 1, 1, 4'b0000));
    step("sf_both", ins(AL, 2'b00, 1, 1, 1, 1, 1, 3'b111), 4'b0000, 1, 1);
    hand("sf_bubble", pk(0, 0, 3'b000, 0, 0, 0, 1, 4'b0000));

    // Stall holds E and defers the flag write
    step("st_load", ins(AL, 2'b11, 1, 0, 0, 1, 0, 3'b011), 4'b0000, 0, 0);
    hand("st_loaded", pk(1, 0, 3'b011, 0, 1, 0, 1, 4'b0000));
    step("st_hold1", ins(EQ, 2'b00, 0, 1, 0, 0, 0, 3'b000), 4'b0011, 1, 0);
    hand("st_held1", pk(1, 0, 3'b011, 0, 1, 0, 1, 4'b0000));
    step("st_hold2", ins(EQ, 2'b00, 0, 1, 0, 0, 0, 3'b000), 4'b0011, 1, 0);
    hand("st_held2", pk(1, 0, 3'b011, 0, 1, 0, 1, 4'b0000));
    step("st_release", ins(EQ, 2'b00, 0, 1, 0, 0, 0, 3'b000), 4'b1100, 0, 0);
    hand("st_written", pk(0, 0, 3'b000, 0, 0, 1, 1, 4'b1100));

    // Flush does not block the outgoing flag write
    step("fl_set", ins(AL, 2'b11, 0, 0, 0, 0, 0, 3'b000), 4'b0000, 0, 0);
    step("fl_flush", ins(AL, 2'b00, 1, 0, 0, 0, 0, 3'b000), 4'b0110, 0, 1);
    hand("fl_flags", pk(0, 0, 3'b000, 0, 0, 0, 1, 4'b0110));

    // Condition 1111
    step("nv", ins(4'b1111, 2'b00, 1, 0, 0, 0, 0, 3'b000), 4'b0000, 0, 0);
`ifdef COND_NV_ALWAYS_EN
    hand("nv_gate", pk(0, 0, 3'b000, 0, 1, 0, 1, 4'b0110));
`else
    hand("nv_gate", pk(0, 0, 3'b000, 0, 0, 0, 0, 4'b0110));
`endif

    // Sweep 16 flag values x 16 conditions
    for (int f = 0; f < 16; f++) begin
      step("sw_set", ins(AL, 2'b11, 0, 0, 0, 0, 0, 3'b000), 4'b0000, 0, 0);
      for (int c = 0; c < 16; c++) begin
        step("sw_cond", ins(4'(c), 2'b00, 1, 1, 1, 0, 0, 3'b000),
             (c == 0) ? 4'(f) : 4'b0000, 0, 0);
      end
    end

    // Asynchronous reset with all flags set
    step("ar_set", ins(AL, 2'b11, 0, 0, 0, 0, 0, 3'b000), 4'b0000, 0, 0);
    step("ar_ones", idle, 4'b1111, 0, 0);
    hand("ar_flags_ones", pk(0, 0, 3'b000, 0, 0, 0, 1, 4'b1111));
    async_reset("ar_now");
    step("post_rst", ins(EQ, 2'b00, 1, 0, 0, 0, 0, 3'b000), 4'b0000, 0, 0);
    step("post_idle", idle, 4'b0000, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
